// File: rtl/detector_tur_pkg.sv
// detector_tur_pkg: shared FSM encodings, timing defaults and counter sizing for the lap detector
package detector_tur_pkg;
  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_CONFIRMA = 2'd1;
  localparam logic [1:0] S_PULS     = 2'd2;
  localparam logic [1:0] S_BLOCARE  = 2'd3;
  localparam int DEBOUNCE_CICLI_DEF = 50000;
  localparam int BLOCARE_CICLI_DEF  = 50000000;
  // One spare bit so the saturating counter can never wrap
  function automatic int cnt_width(input int a, input int b);
    return $clog2(a > b ? a : b) + 1;
  endfunction
endpackage

// File: rtl/detector_tur_if.sv
// detector_tur_if: race enable, sensor bits and lap outputs of the detector
interface detector_tur_if #(parameter int N_SENZORI = 5);
  logic                 activ;
  logic [N_SENZORI-1:0] senzori;
  logic                 puls_tur;
  logic                 blocat;
  modport master (output activ, senzori, input puls_tur, blocat);
  modport slave  (input activ, senzori, output puls_tur, blocat);
endinterface

// File: rtl/detector_tur_sincron_marcaj.sv
// sincron_marcaj: two-flop synchroniser on the raw sensors plus all-ones marker detect
module sincron_marcaj #(
  parameter int N = 5
) (
  input  logic         tact,
  input  logic         reset,
  input  logic [N-1:0] i_senzori,
  output logic         o_marcaj
);
  logic [N-1:0] r_s1, r_s2;
  always_ff @(posedge tact) begin
    if (reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= i_senzori;
      r_s2 <= r_s1;
    end
  end
  assign o_marcaj = &r_s2;
endmodule

// File: rtl/detector_tur.sv
// detector_tur: debounced lap-marker FSM emitting one pulse per crossing followed by a lockout
module detector_tur
  import detector_tur_pkg::*;
#(
  parameter int N_SENZORI      = 5,
  parameter int DEBOUNCE_CICLI = DEBOUNCE_CICLI_DEF,
  parameter int BLOCARE_CICLI  = BLOCARE_CICLI_DEF
) (
  input  logic          tact,
  input  logic          reset,
  detector_tur_if.slave bus
);
  localparam int CW = cnt_width(DEBOUNCE_CICLI, BLOCARE_CICLI);
  localparam logic [CW-1:0] DEB = CW'(DEBOUNCE_CICLI);
  localparam logic [CW-1:0] BLK = CW'(BLOCARE_CICLI);
  logic [1:0]    r_st, w_st;
  logic [CW-1:0] r_cnt, w_cnt;
  logic          r_puls, r_blocat, w_marcaj;
  sincron_marcaj #(.N(N_SENZORI)) u_sincron (
    .tact      (tact),
    .reset     (reset),
    .i_senzori (bus.senzori),
    .o_marcaj  (w_marcaj)
  );
  always_comb begin
    w_st  = r_st;
    w_cnt = r_cnt;
    if (!bus.activ) begin
      w_st  = S_IDLE;
      w_cnt = '0;
    end else begin
      unique case (r_st)
        S_IDLE: if (w_marcaj) begin
          w_st  = S_CONFIRMA;
          w_cnt = CW'(1);
        end
        S_CONFIRMA: if (!w_marcaj) begin
          w_st  = S_IDLE;
          w_cnt = '0;
        end else if (r_cnt >= DEB) begin
          w_st  = S_PULS;
          w_cnt = '0;
        end else w_cnt = r_cnt + 1'b1;
        S_PULS: begin
          w_st  = S_BLOCARE;
          w_cnt = '0;
        end
        // Lockout holds while the marker is still under the sensors
        default: if (r_cnt >= BLK && !w_marcaj) begin
          w_st  = S_IDLE;
          w_cnt = '0;
        end else w_cnt = r_cnt >= BLK ? r_cnt : r_cnt + 1'b1;
      endcase
    end
  end
  always_ff @(posedge tact) begin
    if (reset) begin
      r_st     <= S_IDLE;
      r_cnt    <= '0;
      r_puls   <= 1'b0;
      r_blocat <= 1'b0;
    end else begin
      r_st     <= w_st;
      r_cnt    <= w_cnt;
      r_puls   <= w_st == S_PULS;
      r_blocat <= w_st != S_IDLE;
    end
  end
  assign bus.puls_tur = r_puls;
  assign bus.blocat   = r_blocat;
endmodule

// File: tb/tb_detector_tur.sv
// tb_detector_tur: directed crossing scenarios plus random marker traffic against a rule-level model
module tb_detector_tur;
  localparam int NS = 5, DEB = 4, BLK = 10;
  logic tact = 1'b0, reset = 1'b1;
  detector_tur_if #(.N_SENZORI(NS)) bus ();
  detector_tur #(.N_SENZORI(NS), .DEBOUNCE_CICLI(DEB), .BLOCARE_CICLI(BLK)) dut (
    .tact  (tact),
    .reset (reset),
    .bus   (bus)
  );
  always #5 tact = ~tact;
  int checks = 0, failures = 0, npuls = 0, ntick = 0, first_puls = -1;
  bit d1, d2, e_puls, e_blocat;
  int progress = 0, lock = -1;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  // Reference: marker seen two clocks late, then debounce run, single pulse, saturating lockout
  task automatic model_step();
    bit mk;
    mk = d2;
    if (reset) begin
      d1 = 0; d2 = 0; progress = 0; lock = -1; e_puls = 0; e_blocat = 0;
      return;
    end
    d2 = d1;
    d1 = &bus.senzori;
    if (e_puls) begin
      e_puls = 0;
      lock = bus.activ ? 0 : -1;
    end else if (!bus.activ) begin
      progress = 0;
      lock = -1;
    end else if (lock >= 0) begin
      if (lock >= BLK && !mk) lock = -1;
      else lock = lock >= BLK ? BLK : lock + 1;
    end else if (progress > 0) begin
      if (!mk) progress = 0;
      else if (progress >= DEB) begin
        progress = 0;
        e_puls = 1;
      end else progress++;
    end else if (mk) progress = 1;
    e_blocat = progress > 0 || e_puls || lock >= 0;
  endtask
  task automatic tick();
    @(posedge tact);
    model_step();
    #1;
    ntick++;
    if (bus.puls_tur === 1'b1) begin
      npuls++;
      if (first_puls < 0) first_puls = ntick;
    end
    check("puls_tur", bus.puls_tur, e_puls);
    check("blocat", bus.blocat, e_blocat);
  endtask
  task automatic drive(input logic a, input logic [NS-1:0] s, input int n);
    bus.activ = a;
    bus.senzori = s;
    repeat (n) tick();
  endtask
  task automatic new_scn();
    npuls = 0; ntick = 0; first_puls = -1;
  endtask
  initial begin
    logic [NS-1:0] s;
    bus.activ = 1'b0;
    bus.senzori = '0;
    reset = 1'b1;
    drive(0, '0, 2);
    check("reset_puls", bus.puls_tur, 0);
    check("reset_blocat", bus.blocat, 0);
    reset = 1'b0;
    new_scn();
    drive(1, '1, 2);
    check("r028_blocat_before", bus.blocat, 0);
    drive(1, '1, 1);
    check("r028_blocat_entry", bus.blocat, 1);
    drive(1, '1, 3);
    drive(1, '0, 20);
    check("r028_count", npuls, 1);
    check("r028_latency", first_puls, 7);
    check("r028_blocat_end", bus.blocat, 0);
    new_scn();
    drive(1, '1, 3);
    drive(1, 5'b01111, 8);
    check("r029_count", npuls, 0);
    check("r029_blocat", bus.blocat, 0);
    new_scn();
    drive(1, '1, 30);
    check("r030_blocat_hold", bus.blocat, 1);
    drive(1, '0, 2);
    check("r030_blocat_sync", bus.blocat, 1);
    drive(1, '0, 1);
    check("r030_idle", bus.blocat, 0);
    check("r030_count", npuls, 1);
    new_scn();
    drive(1, '1, 6);
    drive(1, '0, 6);
    drive(1, '1, 4);
    drive(1, '0, 6);
    check("r031_lockout_count", npuls, 1);
    check("r031_idle", bus.blocat, 0);
    drive(1, '1, 6);
    drive(1, '0, 14);
    check("r031_second_count", npuls, 2);
    new_scn();
    drive(1, '1, 5);
    reset = 1'b1;
    drive(1, '1, 1);
    check("r032_reset_puls", bus.puls_tur, 0);
    check("r032_reset_blocat", bus.blocat, 0);
    reset = 1'b0;
    new_scn();
    drive(1, '1, 6);
    check("r032_fresh_wait", npuls, 0);
    drive(1, '1, 1);
    check("r032_fresh_count", npuls, 1);
    check("r032_fresh_latency", first_puls, 7);
    drive(1, '0, 20);
    new_scn();
    drive(1, '1, 3);
    drive(0, '1, 3);
    drive(1, '0, 4);
    check("r033_inactive_count", npuls, 0);
    check("r033_inactive_blocat", bus.blocat, 0);
    new_scn();
    drive(1, '1, 6);
    drive(1, '0, 1);
    check("r033_puls_now", bus.puls_tur, 1);
    drive(0, '0, 1);
    check("r033_after_puls", bus.puls_tur, 0);
    check("r033_idle", bus.blocat, 0);
    drive(1, '0, 5);
    check("r033_count", npuls, 1);
    repeat (40) begin
      s = $urandom_range(0, 1) ? '1 : NS'($urandom);
      reset = $urandom_range(0, 29) == 0;
      drive($urandom_range(0, 9) != 0, s, reset ? 1 : $urandom_range(1, 16));
      reset = 1'b0;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/detector_tur.md
DETECTOR_TUR -- requirements
Module: detector_tur

Interface
REQ-001 The block SHALL have parameter N_SENZORI, default 5, meaning the number of line sensors.
REQ-002 The block SHALL have parameter DEBOUNCE_CICLI, default 50000, meaning the number of consecutive clocks the marker must be held before it is confirmed.
REQ-003 The block SHALL have parameter BLOCARE_CICLI, default 50000000, meaning the number of lockout clocks after a confirmed lap.
REQ-004 The block SHALL have port tact, input, width 1, meaning the single system clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, width 1, meaning the synchronous, active-high reset.
REQ-006 The block SHALL have port activ, input, width 1, meaning race enable; 0 forces IDLE.
REQ-007 The block SHALL have port senzori, input, width N_SENZORI, meaning raw sensor bits, 1 = black line seen.
REQ-008 The block SHALL have port puls_tur, output, width 1, meaning a registered one-clock lap pulse that feeds the lap-counter clock input.
REQ-009 The block SHALL have port blocat, output, width 1, meaning a registered level that is high while the detector is in CONFIRMA, PULS or BLOCARE.

Function
REQ-010 The marker SHALL be defined as all senzori bits = 1, evaluated from a two-flop synchroniser, so detection latency is 2 clocks.
REQ-011 The block SHALL implement the states IDLE, CONFIRMA, PULS and BLOCARE.
REQ-012 From IDLE, if activ=1 and the marker is present, the FSM SHALL go to CONFIRMA and load the counter with 1.
REQ-013 In CONFIRMA, the counter SHALL increment each clock while the marker is present.
REQ-014 In CONFIRMA, any clock without the marker SHALL return the FSM to IDLE with the counter cleared and no pulse emitted.
REQ-015 In CONFIRMA, when the counter reaches DEBOUNCE_CICLI the FSM SHALL go to PULS.
REQ-016 In PULS, puls_tur SHALL be 1 for exactly one clock; the FSM SHALL then go to BLOCARE with the counter cleared.
REQ-017 In BLOCARE, the counter SHALL increment every clock.
REQ-018 The FSM SHALL leave BLOCARE for IDLE only when the counter is >= BLOCARE_CICLI and the marker is absent; if the marker is still present, it SHALL remain in BLOCARE with the counter saturated.
REQ-019 The block SHALL emit at most one puls_tur per physical marker crossing, regardless of crossing duration.
REQ-020 activ=0 in any state SHALL force IDLE on the next clock with the counter cleared; an in-flight PULS cycle still completes its single pulse.
REQ-021 The shared counter SHALL be sized as clog2(max(DEBOUNCE_CICLI, BLOCARE_CICLI))+1 bits and SHALL never wrap.
REQ-022 Marker bounce during BLOCARE SHALL have no effect on the outputs.

Reset
REQ-023 On reset=1 at a rising edge of tact, the FSM SHALL enter IDLE, and the counter and both synchroniser stages SHALL clear.
REQ-024 On reset, puls_tur and blocat SHALL be 0; reset SHALL take priority over every other input.
REQ-025 Reset asserted mid-CONFIRMA or mid-BLOCARE SHALL discard all progress and SHALL NOT emit a pulse.

Structure
REQ-026 The state encodings and the default values of DEBOUNCE_CICLI and BLOCARE_CICLI SHALL live in the shared project constants package or include file, reused by the lap counter and the top level.
REQ-027 The two-flop synchroniser plus all-ones detect SHALL be one sub-module, sincron_marcaj; the FSM and counter SHALL stay in detector_tur.

Verification (bench parameters: N_SENZORI=5, DEBOUNCE_CICLI=4, BLOCARE_CICLI=10)
REQ-028 The bench SHALL hold senzori=5'b11111 for 6 clocks with activ=1 -> exactly one puls_tur, 2+4+1 clocks after the first marker clock; blocat rises at CONFIRMA entry.
REQ-029 The bench SHALL apply a marker glitch of 3 clocks, then 5'b01111 -> no pulse; FSM back in IDLE; blocat=0.
REQ-030 The bench SHALL hold the marker for 30 clocks -> exactly one pulse; blocat stays 1 until the marker clears, and FSM reaches IDLE on the clock after the synchronised clear.
REQ-031 The bench SHALL apply a second valid marker 5 clocks into BLOCARE -> no second pulse; a marker after the lockout ends and the sensors clear -> a second pulse.
REQ-032 The bench SHALL assert reset at CONFIRMA count 3 -> no pulse, outputs 0, and a fresh 4-clock confirmation is required afterwards.
REQ-033 The bench SHALL drive activ=0 during a valid marker -> no pulse; and activ=0 exactly in PULS -> a single pulse, then IDLE.
